// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: command opcodes, rotation modes and FSM states.
// The step counter width here applies only when LED_SEQ_STEP_COUNT_EN is defined.
package led_seq_pkg;

    typedef enum logic [1:0] {
        OP_STOP         = 2'd0,
        OP_START        = 2'd1,
        OP_SET_PERIOD   = 2'd2,
        OP_LOAD_PATTERN = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int STEP_COUNT_WIDTH = 16;

    // Encoding 3 is not a mode of its own and falls back to rotate-left.
    function automatic mode_t decode_mode(input logic [1:0] arg);
        case (arg)
            2'd1:    return MODE_ROR;
            2'd2:    return MODE_BOUNCE;
            default: return MODE_ROL;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Valid/ready command port of the LED sequencer.
// COUNT_WIDTH must match the COUNT_WIDTH of the led_seq_ctrl instance it connects to.
interface led_seq_ctrl_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [COUNT_WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/led_seq_tick.sv
// Step prescaler: counts 0..period-1 while enabled and asserts tick on the last count.
// The count returns to 0 on clear, while disabled, and after each tick.
module led_seq_tick #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [COUNT_WIDTH-1:0] period,
    output logic                   tick
);

    logic [COUNT_WIDTH-1:0] count;

    assign tick = enable && (count == period - COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED rotator sequencer: run/stop FSM, command decode and pattern register.
// Optional feature: define LED_SEQ_STEP_COUNT_EN to add the 16-bit step_count output.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | stopped; prescaler held at 0, pattern held
//   ST_RUN  | prescaler counting; pattern rotates on each tick
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int          COUNT_WIDTH     = 32,
    parameter int          OUTPUT_WIDTH    = 4,
    parameter int          DEFAULT_PERIOD  = 25_000_000,
    parameter logic [15:0] DEFAULT_PATTERN = 16'b0011
) (
    input  logic                    clk,
    input  logic                    rst_n,
    led_seq_ctrl_if.slave           cmd,
    output logic [OUTPUT_WIDTH-1:0] out,
    output logic                    running,
    output logic                    step
`ifdef LED_SEQ_STEP_COUNT_EN
    ,
    output logic [STEP_COUNT_WIDTH-1:0] step_count
`endif
);

    // The bounce counter must hold 0..OUTPUT_WIDTH-2.
    localparam int             BW          = (OUTPUT_WIDTH > 2) ? $clog2(OUTPUT_WIDTH - 1) : 1;
    localparam logic [BW-1:0]  BOUNCE_LAST = BW'(OUTPUT_WIDTH - 2);

    state_t                  state;
    state_t                  state_nxt;
    mode_t                   mode;
    logic                    dir_right;
    logic [BW-1:0]           bounce_cnt;
    logic [COUNT_WIDTH-1:0]  period;
    logic                    ready_q;
    logic                    accept;
    op_t                     op;
    logic                    tick;
    logic                    step_fire;
    logic                    rot_right;
    logic [OUTPUT_WIDTH-1:0] pat_next;

    assign cmd.cmd_ready = ready_q;
    assign accept        = cmd.cmd_valid && ready_q;
    assign op            = op_t'(cmd.cmd_op);

    led_seq_tick #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_RUN),
        .clear  (accept),
        .period (period),
        .tick   (tick)
    );

    // A command in the same cycle as a tick swallows the step.
    assign step_fire = tick && !accept;

    assign rot_right = (mode == MODE_ROR) || ((mode == MODE_BOUNCE) && dir_right);
    assign pat_next  = rot_right ? {out[0], out[OUTPUT_WIDTH-1:1]}
                                 : {out[OUTPUT_WIDTH-2:0], out[OUTPUT_WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (op)
                OP_STOP:  state_nxt = ST_IDLE;
                OP_START: state_nxt = ST_RUN;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            step       <= 1'b0;
            out        <= DEFAULT_PATTERN[OUTPUT_WIDTH-1:0];
            period     <= COUNT_WIDTH'(DEFAULT_PERIOD);
            mode       <= MODE_ROL;
            dir_right  <= 1'b0;
            bounce_cnt <= '0;
        end else begin
            ready_q <= 1'b1;
            step    <= step_fire;
            if (accept) begin
                case (op)
                    OP_START: begin
                        mode       <= decode_mode(cmd.cmd_arg[1:0]);
                        dir_right  <= 1'b0;
                        bounce_cnt <= '0;
                    end
                    OP_SET_PERIOD: begin
                        period <= (cmd.cmd_arg == '0) ? COUNT_WIDTH'(1) : cmd.cmd_arg;
                    end
                    OP_LOAD_PATTERN: begin
                        out <= cmd.cmd_arg[OUTPUT_WIDTH-1:0];
                    end
                    default: begin
                    end
                endcase
            end else if (step_fire) begin
                out <= pat_next;
                if (mode == MODE_BOUNCE) begin
                    if (bounce_cnt == BOUNCE_LAST) begin
                        bounce_cnt <= '0;
                        dir_right  <= !dir_right;
                    end else begin
                        bounce_cnt <= bounce_cnt + BW'(1);
                    end
                end
            end
        end
    end

`ifdef LED_SEQ_STEP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
        end else if (accept && (op == OP_START)) begin
            step_count <= '0;
        end else if (step_fire) begin
            step_count <= step_count + STEP_COUNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with W=4, DEFAULT_PATTERN=0011, DEFAULT_PERIOD=4.
// Define LED_SEQ_STEP_COUNT_EN to also check the step_count output.
module tb_led_seq_ctrl;
    import led_seq_pkg::*;

    localparam int CW = 32;
    localparam int W  = 4;

    typedef struct {
        logic         v;
        logic [1:0]   op;
        logic [31:0]  arg;
        logic [W-1:0] e_out;
        logic         e_run;
        logic         e_step;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] out;
    logic         running;
    logic         step;
`ifdef LED_SEQ_STEP_COUNT_EN
    logic [15:0]  step_count;
`endif

    int checks = 0;
    int errors = 0;

    vec_t         vecs[$];
    logic [W-1:0] rol_seq    [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
    logic [W-1:0] ror_seq    [3] = '{4'b1001, 4'b1100, 4'b0110};
    logic [W-1:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                     4'b0010, 4'b0001, 4'b0010};

    led_seq_ctrl_if #(.COUNT_WIDTH(CW)) cmd_bus ();

    led_seq_ctrl #(
        .COUNT_WIDTH     (CW),
        .OUTPUT_WIDTH    (W),
        .DEFAULT_PERIOD  (4),
        .DEFAULT_PATTERN (16'b0011)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_bus.slave),
        .out        (out),
        .running    (running),
        .step       (step)
`ifdef LED_SEQ_STEP_COUNT_EN
        ,
        .step_count (step_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive the command at the falling edge, check outputs just after the rising edge.
    task automatic cycle(input string name, input logic v, input logic [1:0] op,
                         input logic [31:0] arg, input logic [W-1:0] e_out,
                         input logic e_run, input logic e_step);
        @(negedge clk);
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_arg   = arg;
        @(posedge clk);
        #1;
        check({name, ".out"},     32'(out),               32'(e_out));
        check({name, ".running"}, 32'(running),           32'(e_run));
        check({name, ".step"},    32'(step),              32'(e_step));
        check({name, ".ready"},   32'(cmd_bus.cmd_ready), 32'd1);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [31:0] arg,
                                input logic [W-1:0] e_out, input logic e_run, input logic e_step);
        vec_t r;
        r.v      = v;
        r.op     = op;
        r.arg    = arg;
        r.e_out  = e_out;
        r.e_run  = e_run;
        r.e_step = e_step;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cur;

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'd0;
        cmd_bus.cmd_arg   = '0;

        // Rotate-left at period 4.
        vecs.push_back(mk(1'b1, OP_START, 32'd0, 4'b0011, 1'b1, 1'b0));
        cur = 4'b0011;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 3) cur = rol_seq[s];
                vecs.push_back(mk(1'b0, OP_STOP, 32'd0, cur, 1'b1, c == 3));
            end
        end
        vecs.push_back(mk(1'b1, OP_STOP, 32'd0, 4'b0011, 1'b0, 1'b0));

        // Period 0 stored as 1, rotate-right; STOP collides with a tick.
        vecs.push_back(mk(1'b1, OP_SET_PERIOD, 32'd0, 4'b0011, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_START, 32'd1, 4'b0011, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, OP_STOP, 32'd0, ror_seq[i], 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, OP_STOP, 32'd0, 4'b0110, 1'b0, 1'b0));

        // Bounce from 0001.
        vecs.push_back(mk(1'b1, OP_LOAD_PATTERN, 32'h0000_0001, 4'b0001, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_START, 32'd2, 4'b0001, 1'b1, 1'b0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1'b0, OP_STOP, 32'd0, bounce_seq[i], 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, OP_STOP, 32'd0, 4'b0010, 1'b0, 1'b0));

        // Mode 3 acts as rotate-left; a LOAD in the period-1 cycle suppresses the step.
        vecs.push_back(mk(1'b1, OP_SET_PERIOD, 32'd4, 4'b0010, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_START, 32'd3, 4'b0010, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, OP_STOP, 32'd0, 4'b0010, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, OP_LOAD_PATTERN, 32'hFFFF_FFF6, 4'b0110, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, OP_STOP, 32'd0, 4'b0110, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, OP_STOP, 32'd0, 4'b1100, 1'b1, 1'b1));

        #12;
        check("reset.out",     32'(out),               32'h3);
        check("reset.running", 32'(running),           32'd0);
        check("reset.step",    32'(step),              32'd0);
        check("reset.ready",   32'(cmd_bus.cmd_ready), 32'd0);
`ifdef LED_SEQ_STEP_COUNT_EN
        check("reset.step_count", 32'(step_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.ready_before_edge", 32'(cmd_bus.cmd_ready), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].op, vecs[i].arg,
                  vecs[i].e_out, vecs[i].e_run, vecs[i].e_step);
        end

        // Asynchronous reset mid-run with out = 1100.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out",     32'(out),               32'h3);
        check("async_rst.running", 32'(running),           32'd0);
        check("async_rst.ready",   32'(cmd_bus.cmd_ready), 32'd0);
        check("async_rst.step",    32'(step),              32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            cycle($sformatf("post_rst%0d", i), 1'b0, OP_STOP, 32'd0, 4'b0011, 1'b0, 1'b0);

        // Four steps at the default period, then configuration while stopped.
        cycle("s6.start", 1'b1, OP_START, 32'd0, 4'b0011, 1'b1, 1'b0);
        cur = 4'b0011;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 3) cur = rol_seq[s];
                cycle($sformatf("s6.run%0d_%0d", s, c), 1'b0, OP_STOP, 32'd0, cur, 1'b1, c == 3);
            end
        end
        cycle("s6.stop", 1'b1, OP_STOP, 32'd0, 4'b0011, 1'b0, 1'b0);
        cycle("s6.load", 1'b1, OP_LOAD_PATTERN, 32'h8, 4'b1000, 1'b0, 1'b0);
        cycle("s6.setp", 1'b1, OP_SET_PERIOD, 32'd2, 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle($sformatf("s6.hold%0d", i), 1'b0, OP_STOP, 32'd0, 4'b1000, 1'b0, 1'b0);
`ifdef LED_SEQ_STEP_COUNT_EN
        check("s6.step_count_held", 32'(step_count), 32'd4);
`endif
        cycle("s6.restart", 1'b1, OP_START, 32'd0, 4'b1000, 1'b1, 1'b0);
`ifdef LED_SEQ_STEP_COUNT_EN
        check("s6.step_count_cleared", 32'(step_count), 32'd0);
`endif
        cycle("s6.restart1", 1'b0, OP_STOP, 32'd0, 4'b1000, 1'b1, 1'b0);
        cycle("s6.restart2", 1'b0, OP_STOP, 32'd0, 4'b0001, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
